// File: rtl/adam_aes_pkg.sv
// Shared types and defaults for the AES key-schedule controller slice.
package adam_aes_pkg;

  // Controller sequencing: accept, kick the expander, wait for it, respond.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Expander completion budget used when the instantiating block does not override it.
  localparam int TIMEOUT_DEFAULT = 32;

  localparam int KEY_W     = 128;
  localparam int EXP_KEY_W = 256;

endpackage

// File: rtl/adam_aes_rr_arbiter.sv
// Round-robin grant selection: first asserted request at or after the pointer,
// wrapping modulo NREQ. Purely combinational; the caller owns the pointer.
module adam_aes_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Rotating priority scan starting from the pointer position.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/adam_aes_key_sched_ctrl.sv
// Arbitrates several requesters onto one AES-128 key expansion unit and keeps
// a one-entry cache of the last expanded key so repeat requests skip expansion.
//
// Handshake: a requester holds req_valid (and a stable req_key) until it sees
// req_ready, which is a combinational one-hot pulse raised only in IDLE for the
// round-robin winner; the request is latched on that same edge. Exactly one
// rsp_valid pulse later returns to that requester, qualified by rsp_hit
// (cache hit, no expansion) or rsp_err (expander timed out), never both.
// A synchronous reset abandons any in-flight request without a response.
module adam_aes_key_sched_ctrl
  import adam_aes_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][KEY_W-1:0]  req_key,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             rsp_valid,
  output logic                        rsp_hit,
  output logic                        rsp_err,
  output logic [EXP_KEY_W-1:0]        exp_key,
  output logic                        exp_keylen,
  output logic                        exp_init,
  input  logic                        exp_ready,
  input  logic                        flush,
  output logic [IW-1:0]               owner_id,
  output logic                        owner_valid,
  output logic                        busy,
  output state_t                      dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [KEY_W-1:0]     key_q;
  logic [IW-1:0]        id_q;
  logic [KEY_W-1:0]     cache_tag;
  logic                 cache_valid;
  logic [CW-1:0]        wait_cnt;

  logic [NREQ-1:0]      gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 key_hit;
  logic [NREQ-1:0]      id_onehot;

  adam_aes_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // A flush in the accept cycle forces a miss even if the tag matches.
  assign key_hit    = cache_valid && !flush && (req_key[gnt_idx] == cache_tag);
  assign id_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
  assign req_ready  = (state == ST_IDLE && reset_n) ? gnt : '0;
  assign busy       = (state != ST_IDLE);
  assign exp_keylen = 1'b0;
  assign dbg_state  = state;

  // Sequencing, cache bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      key_q       <= '0;
      id_q        <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      wait_cnt    <= '0;
      owner_id    <= '0;
      owner_valid <= 1'b0;
      rsp_valid   <= '0;
      rsp_hit     <= 1'b0;
      rsp_err     <= 1'b0;
      exp_init    <= 1'b0;
      exp_key     <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_hit   <= 1'b0;
      rsp_err   <= 1'b0;
      exp_init  <= 1'b0;
      if (flush) cache_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            key_q  <= req_key[gnt_idx];
            id_q   <= gnt_idx;
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (key_hit) begin
              state     <= ST_DONE;
              rsp_valid <= gnt;
              rsp_hit   <= 1'b1;
            end else begin
              state       <= ST_START;
              exp_init    <= 1'b1;
              exp_key     <= {req_key[gnt_idx], {KEY_W{1'b0}}};
              owner_valid <= 1'b0;
            end
          end
        end

        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (exp_ready) begin
            cache_tag   <= key_q;
            cache_valid <= !flush;
            owner_id    <= id_q;
            owner_valid <= 1'b1;
            rsp_valid   <= id_onehot;
            state       <= ST_DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            cache_valid <= 1'b0;
            owner_valid <= 1'b0;
            rsp_valid   <= id_onehot;
            rsp_err     <= 1'b1;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adam_aes_key_sched_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model of the controller.
module tb_adam_aes_key_sched_ctrl;

  localparam int NREQ = 2;
  localparam int TO   = 32;
  localparam int IW   = 1;

  localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] K4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] K6 = 128'h13579bdf2468ace013579bdf2468ace0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset_n;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0][127:0]       req_key;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0]              rsp_valid;
  logic                         rsp_hit, rsp_err;
  logic [255:0]                 exp_key;
  logic                         exp_keylen, exp_init;
  logic                         exp_ready, flush;
  logic [IW-1:0]                owner_id;
  logic                         owner_valid, busy;
  logic [1:0]                   dbg_state;

  adam_aes_key_sched_ctrl #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_key     (req_key),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_hit     (rsp_hit),
    .rsp_err     (rsp_err),
    .exp_key     (exp_key),
    .exp_keylen  (exp_keylen),
    .exp_init    (exp_init),
    .exp_ready   (exp_ready),
    .flush       (flush),
    .owner_id    (owner_id),
    .owner_valid (owner_valid),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int force_delay = -1;

  // scoreboard of expected response qualifiers {hit, err}
  logic [1:0] exp_q[$];

  // transaction-level model state
  bit           m_valid_state = 0;
  bit           m_rst, m_busy, m_miss, m_hit, m_err, m_resp_known;
  int           m_acc, m_resp_cyc, m_rdy_cyc, m_id, m_oid, m_ptr;
  logic [127:0] m_key, m_tag;
  bit           m_cv, m_ov;

  // DUT observations for directed checks
  int n_init, n_rsp, n_grant, acc_cyc, rsp_cyc, g_first, g_second;
  logic [NREQ-1:0] rsp_vec;
  logic rsp_h, rsp_e;

  logic [127:0] pool [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  task automatic chk_key(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d actual=no-event expected=event-within-budget", name, cyc);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit m_waiting();
    return m_busy && m_miss && !m_resp_known && (cyc >= m_acc + 2);
  endfunction

  task automatic clear_obs();
    n_init = 0; n_rsp = 0; n_grant = 0; acc_cyc = -1; rsp_cyc = -1;
    g_first = -1; g_second = -1; rsp_vec = '0; rsp_h = 1'b0; rsp_e = 1'b0;
  endtask

  // ---------------- driver: expander behaviour ----------------
  task automatic drive_expander(input bit spurious_ok);
    exp_ready = m_waiting() && (cyc == m_rdy_cyc);
    if (spurious_ok && !m_waiting() && $urandom_range(0, 15) == 0) exp_ready = 1'b1;
  endtask

  // ---------------- one cycle: compare, then advance model ----------------
  task automatic step();
    logic [NREQ-1:0] e_rdy, e_rsp;
    logic [1:0]      sb;
    int  w, d;
    bit  granted;
    bit  nv;
    granted = 0;
    @(negedge clk);
    #1;
    w = winner(req_valid, m_ptr);

    if (m_valid_state) begin
      e_rdy = (!m_busy && reset_n && w >= 0) ? onehot(w) : '0;
      e_rsp = (m_busy && m_resp_known && cyc == m_resp_cyc) ? onehot(m_id) : '0;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("rsp_hit",   32'(rsp_hit),   32'((e_rsp != 0) && m_hit));
      chk("rsp_err",   32'(rsp_err),   32'((e_rsp != 0) && m_err));
      chk("exp_init",  32'(exp_init),  32'(m_busy && m_miss && cyc == m_acc + 1));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("exp_keylen", 32'(exp_keylen), 0);
      chk("owner_id",  32'(owner_id),  32'(m_oid));
      chk("owner_valid", 32'(owner_valid), 32'(m_ov));
      if (m_rst)
        chk_key("exp_key_rst", exp_key, 256'(0));
      else if (m_busy && m_miss && cyc >= m_acc + 1 && !(m_resp_known && cyc >= m_resp_cyc))
        chk_key("exp_key", exp_key, {m_key, 128'b0});

      if (exp_init === 1'b1) n_init++;
      if (|req_ready) begin
        acc_cyc = cyc;
        if (n_grant == 0) g_first = winner(req_ready, 0);
        if (n_grant == 1) g_second = winner(req_ready, 0);
        n_grant++;
      end
      if (|rsp_valid) begin
        n_rsp++; rsp_cyc = cyc; rsp_vec = rsp_valid; rsp_h = rsp_hit; rsp_e = rsp_err;
        if (exp_q.size() == 0) begin
          bound_fail("rsp_unexpected");
        end else begin
          sb = exp_q.pop_front();
          chk("sb_rsp_qual", 32'({rsp_hit, rsp_err}), 32'(sb));
        end
      end
    end

    if (!reset_n) begin
      m_busy = 0; m_cv = 0; m_tag = '0; m_oid = 0; m_ov = 0; m_ptr = 0;
      m_rst = 1; m_valid_state = 1; m_resp_known = 0; m_miss = 0; m_hit = 0; m_err = 0;
      exp_q.delete();
    end else begin
      m_rst = 0;
      nv = m_cv;
      if (!m_busy) begin
        if (w >= 0) begin
          granted = 1;
          m_busy = 1; m_id = w; m_key = req_key[w]; m_acc = cyc; m_err = 0;
          m_hit  = m_cv && !flush && (req_key[w] == m_tag);
          m_miss = !m_hit;
          m_ptr  = (w + 1) % NREQ;
          if (m_hit) begin
            m_resp_known = 1; m_resp_cyc = cyc + 1; exp_q.push_back(2'b10);
          end else begin
            m_resp_known = 0; m_ov = 0;
            if (force_delay >= 0) d = force_delay;
            else if ($urandom_range(0, 3) == 0) d = $urandom_range(1, TO + 8);
            else d = $urandom_range(1, 6);
            m_rdy_cyc = cyc + 1 + d;
          end
        end
      end else if (m_resp_known && cyc == m_resp_cyc) begin
        m_busy = 0;
      end else if (m_waiting()) begin
        if (exp_ready) begin
          m_tag = m_key; nv = 1; m_oid = m_id; m_ov = 1;
          m_resp_known = 1; m_resp_cyc = cyc + 1; exp_q.push_back(2'b00);
        end else if (cyc == m_acc + 1 + TO) begin
          nv = 0; m_ov = 0; m_err = 1;
          m_resp_known = 1; m_resp_cyc = cyc + 1; exp_q.push_back(2'b01);
        end
      end
      if (flush) nv = 0;
      m_cv = nv;
    end

    @(posedge clk);
    #1;
    cyc++;
    if (granted) req_valid[w] = 1'b0;
  endtask

  task automatic run_rsp(input int want, input int budget, input string name);
    int k;
    k = 0;
    while (n_rsp < want && k < budget) begin
      drive_expander(0);
      step();
      k++;
    end
    exp_ready = 1'b0;
    if (n_rsp < want) bound_fail(name);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0; req_valid = '0; flush = 1'b0; exp_ready = 1'b0;
    for (int i = 0; i < n; i++) step();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pool[0] = K0; pool[1] = K1; pool[2] = K2; pool[3] = K3;
    req_key = '0;
    clear_obs();
    do_reset(2);
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner_valid", 32'(owner_valid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk_key("rst_exp_key_lit", exp_key, 256'(0));

    // first miss, expander answers 13 cycles after exp_init
    clear_obs(); force_delay = 13;
    req_valid = 2'b01; req_key[0] = K0;
    run_rsp(1, 80, "t1_rsp_bound");
    chk("t1_n_init", n_init, 1);
    chk("t1_rsp_vec", 32'(rsp_vec), 32'h1);
    chk("t1_hit", 32'(rsp_h), 0);
    chk("t1_latency", rsp_cyc - acc_cyc, 15);
    chk("t1_owner_id", 32'(owner_id), 0);
    chk("t1_owner_valid", 32'(owner_valid), 1);

    // same key from requester 1 hits
    clear_obs();
    req_valid = 2'b10; req_key[1] = K0;
    run_rsp(1, 10, "t2_rsp_bound");
    chk("t2_n_init", n_init, 0);
    chk("t2_rsp_vec", 32'(rsp_vec), 32'h2);
    chk("t2_hit", 32'(rsp_h), 1);
    chk("t2_latency", rsp_cyc - acc_cyc, 1);

    // simultaneous requests after reset: req0 then req1
    do_reset(1);
    clear_obs(); force_delay = 3;
    req_valid = 2'b11; req_key[0] = K1; req_key[1] = K2;
    run_rsp(2, 120, "t3_rsp_bound");
    chk("t3_first", g_first, 0);
    chk("t3_second", g_second, 1);
    chk("t3_n_init", n_init, 2);

    // expander never answers: timeout, then the same key misses
    do_reset(1);
    clear_obs(); force_delay = 1000;
    req_valid = 2'b01; req_key[0] = K3;
    run_rsp(1, TO + 20, "t4_rsp_bound");
    chk("t4_err", 32'(rsp_e), 1);
    chk("t4_hit", 32'(rsp_h), 0);
    chk("t4_wait_to_rsp", rsp_cyc - (acc_cyc + 2), TO);
    chk("t4_owner_valid", 32'(owner_valid), 0);
    clear_obs(); force_delay = 2;
    req_valid = 2'b01;
    run_rsp(1, 20, "t4b_rsp_bound");
    chk("t4b_n_init", n_init, 1);
    chk("t4b_hit", 32'(rsp_h), 0);
    chk("t4b_err", 32'(rsp_e), 0);

    // flush between identical requests forces re-expansion
    clear_obs();
    req_valid = 2'b01; req_key[0] = K4;
    run_rsp(1, 20, "t5a_rsp_bound");
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_obs();
    req_valid = 2'b01;
    run_rsp(1, 20, "t5_rsp_bound");
    chk("t5_hit", 32'(rsp_h), 0);
    chk("t5_n_init", n_init, 1);

    // reset during WAIT: silent abort, cache lost
    clear_obs(); force_delay = 1000;
    req_valid = 2'b01; req_key[0] = K6;
    for (int i = 0; i < 6; i++) begin drive_expander(0); step(); end
    do_reset(1);
    clear_obs();
    for (int i = 0; i < 40; i++) step();
    chk("t6_no_rsp", n_rsp, 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_owner_valid", 32'(owner_valid), 0);
    clear_obs(); force_delay = 2;
    req_valid = 2'b01; req_key[0] = K4;
    run_rsp(1, 20, "t6b_rsp_bound");
    chk("t6b_hit", 32'(rsp_h), 0);
    chk("t6b_n_init", n_init, 1);

    // randomized traffic
    force_delay = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_key[i]   = pool[$urandom_range(0, 3)];
        end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      flush   = ($urandom_range(0, 15) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      drive_expander(1);
      step();
    end

    // drain
    req_valid = '0; flush = 1'b0; reset_n = 1'b1;
    begin
      int k;
      k = 0;
      while (m_busy && k < TO + 20) begin drive_expander(0); step(); k++; end
      if (m_busy) bound_fail("drain_bound");
    end
    exp_ready = 1'b0;
    step();
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
